bbq_traffic_gen: RTL and testbench

Parametrised, mode-selectable stimulus generator and result monitor for the `bbq` heap. It replaces the fixed alternating enqueue/dequeue driver in the FPGA top level. It tracks heap occupancy so it never dequeues from an empty heap or enqueues into a full one. It folds every heap output into a running checksum and counts issued operations and returned results, so a hardware run can be checked with no external logic.

---
 rtl/bbq_tg_pkg.sv | 25 ++
 rtl/heap_ops.sv | 9 +
 rtl/bbq_lfsr32.sv | 21 ++
 rtl/bbq_traffic_gen.sv | 171 +++++++++++++++++
 tb/tb_bbq_traffic_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bbq_tg_pkg.sv
// Types and helpers for the bbq traffic generator.
package bbq_tg_pkg;

    typedef enum logic [1:0] {
        TG_ALT      = 2'd0,
        TG_BURST    = 2'd1,
        TG_RAND     = 2'd2,
        TG_ENQ_ONLY = 2'd3
    } tg_mode_t;

    typedef enum logic [1:0] {
        TG_IDLE      = 2'd0,
        TG_INIT_WAIT = 2'd1,
        TG_RUN       = 2'd2,
        TG_DRAIN     = 2'd3
    } tg_state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] rotl16(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction

endpackage

// File: rtl/heap_ops.sv
// Heap operation encoding shared by the bbq heap and its drivers.
package heap_ops;

    typedef enum logic {
        ENQUE     = 1'b0,
        DEQUE_MIN = 1'b1
    } heap_op_t;

endpackage

// File: rtl/bbq_lfsr32.sv
// 32-bit right-shifting Galois LFSR, stepped once per asserted advance.
module bbq_lfsr32
    import bbq_tg_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        user_clk,
    input  logic        arst,
    input  logic        advance,
    output logic [31:0] lfsr
);

    always_ff @(posedge user_clk) begin
        if (arst) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/bbq_traffic_gen.sv
// Mode-selectable op generator and result monitor for the bbq heap.
// Valid/ready: an op is decided only when heap_ready=1 and is presented the next cycle for one cycle.
module bbq_traffic_gen
    import heap_ops::*;
    import bbq_tg_pkg::*;
#(
    parameter int          ENTRY_DWIDTH    = 17,
    parameter int          PRIORITY_AWIDTH = 15,
    parameter int          MAX_ENTRIES     = (1 << 17) - 1,
    parameter int          BURST_LEN       = 16,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
    localparam int         OCC_W           = $clog2(MAX_ENTRIES + 1)
) (
    input  logic                       user_clk,
    input  logic                       arst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [1:0]                 mode,
    input  logic                       heap_ready,
    output logic                       heap_in_valid,
    output heap_op_t                   heap_in_op_type,
    output logic [ENTRY_DWIDTH-1:0]    heap_in_he_data,
    output logic [PRIORITY_AWIDTH-1:0] heap_in_he_priority,
    input  logic                       heap_out_valid,
    input  heap_op_t                   heap_out_op_type,
    input  logic [ENTRY_DWIDTH-1:0]    heap_out_he_data,
    input  logic [PRIORITY_AWIDTH-1:0] heap_out_he_priority,
    output logic [OCC_W-1:0]           occupancy,
    output logic [63:0]                enq_count,
    output logic [63:0]                deq_count,
    output logic [63:0]                deq_result_count,
    output logic [31:0]                checksum,
    output logic                       busy,
    output logic                       done,
    output tg_state_t                  dbg_state
);

    localparam int               BW         = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0]    BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [OCC_W-1:0] OCC_MAX    = OCC_W'(MAX_ENTRIES);

    tg_state_t     state;
    tg_mode_t      mode_q;
    logic [63:0]   seq;
    logic [BW-1:0] burst_cnt;
    logic          burst_deq;
    logic [31:0]   lfsr;
    logic          req_enq;
    logic          issue;
    logic          issue_enq;
    logic          occ_zero;
    logic          occ_full;

    assign occ_zero  = (occupancy == '0);
    assign occ_full  = (occupancy == OCC_MAX);
    assign busy      = (state != TG_IDLE);
    assign dbg_state = state;

    bbq_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .user_clk (user_clk),
        .arst     (arst),
        .advance  (issue),
        .lfsr     (lfsr)
    );

    always_comb begin
        unique case (mode_q)
            TG_ALT:   req_enq = ~seq[0];
            TG_BURST: req_enq = ~burst_deq;
            TG_RAND:  req_enq = lfsr[0];
            default:  req_enq = 1'b1;
        endcase

        issue     = 1'b0;
        issue_enq = 1'b0;
        if (state == TG_RUN && heap_ready) begin
            issue     = 1'b1;
            issue_enq = req_enq;
            // Occupancy guards keep the heap from under- or overflowing.
            if (!req_enq && occ_zero) begin
                issue_enq = 1'b1;
            end else if (req_enq && occ_full) begin
                if (mode_q == TG_ENQ_ONLY) issue = 1'b0;
                else                       issue_enq = 1'b0;
            end
        end else if (state == TG_DRAIN && heap_ready && !occ_zero) begin
            issue = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (arst) begin
            state               <= TG_IDLE;
            mode_q              <= TG_ALT;
            seq                 <= '0;
            burst_cnt           <= '0;
            burst_deq           <= 1'b0;
            heap_in_valid       <= 1'b0;
            heap_in_op_type     <= ENQUE;
            heap_in_he_data     <= '0;
            heap_in_he_priority <= '0;
            occupancy           <= '0;
            enq_count           <= '0;
            deq_count           <= '0;
            deq_result_count    <= '0;
            checksum            <= '0;
            done                <= 1'b0;
        end else begin
            heap_in_valid <= issue;
            done          <= 1'b0;

            if (issue) begin
                seq <= seq + 64'd1;
                if (burst_cnt == BURST_LAST) begin
                    burst_cnt <= '0;
                    burst_deq <= ~burst_deq;
                end else begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
                if (issue_enq) begin
                    heap_in_op_type     <= ENQUE;
                    heap_in_he_data     <= seq[ENTRY_DWIDTH-1:0];
                    heap_in_he_priority <= (mode_q == TG_RAND) ? lfsr[PRIORITY_AWIDTH-1:0]
                                                               : seq[PRIORITY_AWIDTH-1:0];
                    occupancy           <= occupancy + OCC_W'(1);
                    enq_count           <= enq_count + 64'd1;
                end else begin
                    heap_in_op_type     <= DEQUE_MIN;
                    heap_in_he_data     <= '0;
                    heap_in_he_priority <= '0;
                    occupancy           <= occupancy - OCC_W'(1);
                    deq_count           <= deq_count + 64'd1;
                end
            end

            if (heap_out_valid) begin
                checksum <= {checksum[30:0], checksum[31]} ^ 32'(heap_out_he_data)
                          ^ rotl16(32'(heap_out_he_priority)) ^ 32'(heap_out_op_type);
                if (heap_out_op_type == DEQUE_MIN) deq_result_count <= deq_result_count + 64'd1;
            end

            unique case (state)
                TG_IDLE: begin
                    // A new run starts from clean statistics; the LFSR keeps running.
                    if (start) begin
                        state            <= TG_INIT_WAIT;
                        mode_q           <= tg_mode_t'(mode);
                        seq              <= '0;
                        burst_cnt        <= '0;
                        burst_deq        <= 1'b0;
                        occupancy        <= '0;
                        enq_count        <= '0;
                        deq_count        <= '0;
                        deq_result_count <= '0;
                        checksum         <= '0;
                    end
                end
                TG_INIT_WAIT: if (heap_ready) state <= TG_RUN;
                TG_RUN:       if (stop) state <= TG_DRAIN;
                TG_DRAIN: begin
                    if (occ_zero && !heap_in_valid) begin
                        state <= TG_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= TG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbq_traffic_gen.sv
// Randomised bench for bbq_traffic_gen against a behavioural model of the generator rules.
module tb_bbq_traffic_gen;
    import heap_ops::*;
    import bbq_tg_pkg::*;

    localparam int          ED   = 17;
    localparam int          PA   = 15;
    localparam int          MAXE = 5;
    localparam int          BL   = 4;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int          OW   = $clog2(MAXE + 1);
    localparam int          W    = 1 + ED + PA;

    logic            user_clk = 1'b0;
    logic            arst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic            heap_ready = 1'b0;
    logic            heap_in_valid;
    heap_op_t        heap_in_op_type;
    logic [ED-1:0]   heap_in_he_data;
    logic [PA-1:0]   heap_in_he_priority;
    logic            heap_out_valid = 1'b0;
    heap_op_t        heap_out_op_type = ENQUE;
    logic [ED-1:0]   heap_out_he_data = '0;
    logic [PA-1:0]   heap_out_he_priority = '0;
    logic [OW-1:0]   occupancy;
    logic [63:0]     enq_count, deq_count, deq_result_count;
    logic [31:0]     checksum;
    logic            busy, done;
    tg_state_t       dbg_state;

    bbq_traffic_gen #(
        .ENTRY_DWIDTH(ED), .PRIORITY_AWIDTH(PA), .MAX_ENTRIES(MAXE),
        .BURST_LEN(BL), .LFSR_SEED(SEED)
    ) dut (
        .user_clk(user_clk), .arst(arst), .start(start), .stop(stop), .mode(mode),
        .heap_ready(heap_ready), .heap_in_valid(heap_in_valid),
        .heap_in_op_type(heap_in_op_type), .heap_in_he_data(heap_in_he_data),
        .heap_in_he_priority(heap_in_he_priority), .heap_out_valid(heap_out_valid),
        .heap_out_op_type(heap_out_op_type), .heap_out_he_data(heap_out_he_data),
        .heap_out_he_priority(heap_out_he_priority), .occupancy(occupancy),
        .enq_count(enq_count), .deq_count(deq_count), .deq_result_count(deq_result_count),
        .checksum(checksum), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 user_clk = ~user_clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // scoreboard and model state
    int          errors = 0;
    int          checks = 0;
    logic [W-1:0] exp_q[$];
    int          m_state;       // 0 idle, 1 waiting for heap, 2 running, 3 draining
    int          m_occ;
    logic [63:0] m_seq, m_enq, m_deq, m_res;
    logic [31:0] m_lfsr, m_chk;
    logic [1:0]  m_mode;
    bit          m_valid;
    bit          exp_v, exp_done;
    int          done_seen, drain_deqs, obs_max, bad_deq, prev_occ;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] fold(input logic [31:0] c, input logic [31:0] d,
                                         input logic [31:0] p, input logic [31:0] op);
        return ((c << 1) | (c >> 31)) ^ d ^ ((p << 16) | (p >> 16)) ^ op;
    endfunction

    task automatic model_reset();
        m_state = 0; m_occ = 0; m_seq = 0; m_enq = 0; m_deq = 0; m_res = 0;
        m_chk = 0; m_lfsr = SEED; m_mode = 0; m_valid = 0;
        exp_q.delete();
    endtask

    task automatic model_issue(input bit enq);
        logic [ED-1:0] d;
        logic [PA-1:0] p;
        d = enq ? ED'(m_seq) : '0;
        p = !enq ? '0 : (m_mode == 2'd2) ? PA'(m_lfsr) : PA'(m_seq);
        exp_q.push_back({enq ? 1'b0 : 1'b1, d, p});
        exp_v  = 1;
        m_lfsr = lfsr_next(m_lfsr);
        m_seq  = m_seq + 1;
        if (enq) begin m_occ++; m_enq++; end
        else     begin m_occ--; m_deq++; end
    endtask

    // driver: one clock cycle of stimulus, model update and checking
    task automatic tick(input logic rdy, input logic st, input logic sp, input logic [1:0] md);
        bit            enq, go;
        int            nxt;
        logic [W-1:0]  e;
        heap_ready = rdy; start = st; stop = sp; mode = md;
        exp_v = 0; exp_done = 0; nxt = m_state;
        if (heap_out_valid) begin
            m_chk = fold(m_chk, 32'(heap_out_he_data), 32'(heap_out_he_priority),
                         32'(heap_out_op_type));
            if (heap_out_op_type == DEQUE_MIN) m_res++;
        end
        case (m_state)
            0: if (st) begin
                nxt = 1; m_seq = 0; m_occ = 0; m_enq = 0; m_deq = 0; m_res = 0;
                m_chk = 0; m_mode = md;
            end
            1: if (rdy) nxt = 2;
            2: begin
                if (rdy) begin
                    case (m_mode)
                        2'd0:    enq = (m_seq % 2) == 0;
                        2'd1:    enq = ((m_seq / BL) % 2) == 0;
                        2'd2:    enq = m_lfsr[0];
                        default: enq = 1;
                    endcase
                    go = 1;
                    if (!enq && m_occ == 0) enq = 1;
                    else if (enq && m_occ == MAXE) begin
                        if (m_mode == 2'd3) go = 0;
                        else enq = 0;
                    end
                    if (go) model_issue(enq);
                end
                if (sp) nxt = 3;
            end
            default: begin
                if (m_occ == 0 && !m_valid) begin nxt = 0; exp_done = 1; end
                else if (rdy && m_occ > 0) model_issue(0);
            end
        endcase
        m_state = nxt;
        m_valid = exp_v;
        prev_occ = int'(occupancy);

        @(posedge user_clk); #1;
        check_eq("in_valid", heap_in_valid, exp_v);
        if (heap_in_valid) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '1;
            check_eq("op_fields", {heap_in_op_type, heap_in_he_data, heap_in_he_priority}, e);
            if (heap_in_op_type == DEQUE_MIN && prev_occ == 0) bad_deq++;
        end
        exp_q.delete();
        check_eq("occupancy", occupancy, m_occ);
        check_eq("enq_count", enq_count, m_enq);
        check_eq("deq_count", deq_count, m_deq);
        check_eq("checksum", checksum, m_chk);
        check_eq("deq_result_count", deq_result_count, m_res);
        check_eq("busy", busy, m_state != 0);
        check_eq("done", done, exp_done);
        if (done) done_seen++;
        if (int'(occupancy) > obs_max) obs_max = int'(occupancy);
        @(negedge user_clk);
        start = 0; stop = 0;
    endtask

    task automatic do_reset();
        arst = 1;
        @(posedge user_clk); #1;
        check_eq("rst_in_valid", heap_in_valid, 0);
        check_eq("rst_op_type", heap_in_op_type, ENQUE);
        check_eq("rst_data", heap_in_he_data, 0);
        check_eq("rst_prio", heap_in_he_priority, 0);
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_enq_count", enq_count, 0);
        check_eq("rst_deq_count", deq_count, 0);
        check_eq("rst_result_count", deq_result_count, 0);
        check_eq("rst_checksum", checksum, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_state", dbg_state, TG_IDLE);
        @(negedge user_clk);
        arst = 0;
        model_reset();
    endtask

    task automatic run_to(input logic [1:0] md);
        tick(1, 1, 0, md);
        tick(1, 0, 0, md);
    endtask

    task automatic drain_to_idle(input bit rnd, input int exp_deqs);
        int d0;
        d0 = done_seen;
        drain_deqs = 0;
        tick(0, 0, 1, 0);
        for (int i = 0; i < 60 && m_state != 0; i++) begin
            tick(rnd ? logic'($urandom_range(0, 1)) : 1'b1, 0, 0, 0);
            if (heap_in_valid) drain_deqs++;
        end
        check_eq("drain_busy", busy, 0);
        check_eq("drain_done_pulses", done_seen - d0, 1);
        if (exp_deqs >= 0) check_eq("drain_deqs", drain_deqs, exp_deqs);
    endtask

    initial begin
        done_seen = 0; bad_deq = 0; obs_max = 0;
        model_reset();
        @(negedge user_clk);
        do_reset();

        // ALT: 8 ops alternate, counts end balanced
        run_to(2'd0);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
        check_eq("alt_enq", enq_count, 4);
        check_eq("alt_deq", deq_count, 4);
        drain_to_idle(0, 0);

        // BURST with ready toggling
        obs_max = 0;
        run_to(2'd1);
        for (int i = 0; i < 24; i++) tick(logic'(i % 2 == 0), 0, 0, 0);
        check_eq("burst_peak", obs_max, BL);
        drain_to_idle(0, BL);

        // ENQ_ONLY saturates at capacity
        run_to(2'd3);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
        check_eq("full_occupancy", occupancy, MAXE);
        check_eq("full_in_valid", heap_in_valid, 0);
        drain_to_idle(0, MAXE);

        // stop with three entries outstanding
        run_to(2'd3);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        drain_to_idle(0, 3);

        // RAND from the reset seed
        do_reset();
        bad_deq = 0;
        run_to(2'd2);
        for (int i = 0; i < 40; i++) tick(logic'($urandom_range(0, 3) != 0), 0, 0, 0);
        drain_to_idle(1, -1);
        check_eq("deq_at_empty", bad_deq, 0);

        // monitor fold, then reset in the middle of a run
        run_to(2'd3);
        for (int i = 1; i <= 3; i++) begin
            heap_out_valid = 1; heap_out_op_type = DEQUE_MIN;
            heap_out_he_data = ED'(i); heap_out_he_priority = PA'(i + 4);
            tick(0, 0, 0, 0);
        end
        heap_out_valid = 0;
        tick(0, 0, 0, 0);
        check_eq("mon_result_count", deq_result_count, 3);
        tick(1, 0, 0, 0);
        heap_ready = 1;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
